axi4_lite_master_arbiter: RTL and testbench

//  Shares one AXI4-Lite master port between N_REQ local requesters using a simple req/ready/rsp interface.

---
 rtl/axi4_lite_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/axi4_lite_master_arbiter.sv | 178 +++++++++++++++++
 tb/tb_axi4_lite_master_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared constants for the AXI4-Lite master arbiter: response codes, FSM encoding, default widths.
package axi4_lite_pkg;

  localparam int DEF_N_REQ = 2;
  localparam int DEF_AW    = 32;
  localparam int DEF_DW    = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_DONE
  } state_e;

  // Width of a requester index; never zero so a single-requester build still has a legal vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after the pointer, wrapping.
module rr_arbiter
  import axi4_lite_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IW    = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic             o_valid,
  output logic [IW-1:0]    o_idx,
  output logic [N_REQ-1:0] o_onehot
);

  logic [IW:0] w_cand;

  // Scan from the farthest candidate back to the pointer so the closest one wins.
  always_comb begin
    o_valid  = 1'b0;
    o_idx    = '0;
    o_onehot = '0;
    w_cand   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_cand = {1'b0, i_ptr} + (IW + 1)'(k);
      if (w_cand >= (IW + 1)'(N_REQ)) begin
        w_cand = w_cand - (IW + 1)'(N_REQ);
      end
      if (i_req[w_cand[IW-1:0]]) begin
        o_valid = 1'b1;
        o_idx   = w_cand[IW-1:0];
      end
    end
    o_onehot[o_idx] = o_valid;
  end

endmodule

// File: rtl/axi4_lite_master_arbiter.sv
// Shares one AXI4-Lite master port between N_REQ requesters, one transaction at a time,
// round-robin granted and sequenced through AW/W/B or AR/R before a one-cycle completion pulse.
module axi4_lite_master_arbiter
  import axi4_lite_pkg::*;
#(
  parameter int         N_REQ = DEF_N_REQ,
  parameter int         AW    = DEF_AW,
  parameter int         DW    = DEF_DW,
  parameter logic [2:0] PROT  = 3'b000
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ-1:0]      req_write,
  input  logic [N_REQ*AW-1:0]   req_addr,
  input  logic [N_REQ*DW-1:0]   req_wdata,
  input  logic [N_REQ*DW/8-1:0] req_wstrb,
  output logic [N_REQ-1:0]      req_ready,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [DW-1:0]         rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [AW-1:0]         awaddr,
  output logic [2:0]            awprot,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DW-1:0]         wdata,
  output logic [DW/8-1:0]       wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic [AW-1:0]         araddr,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DW-1:0]         rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready
);

  localparam int IW = idx_width(N_REQ);
  localparam int SW = DW / 8;

  state_e           r_state;
  logic [IW-1:0]    r_ptr;
  logic [N_REQ-1:0] r_gnt_onehot;
  logic [AW-1:0]    r_addr;
  logic [DW-1:0]    r_wdata;
  logic [SW-1:0]    r_wstrb;
  logic             r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
  logic [N_REQ-1:0] r_rsp_valid;
  logic [DW-1:0]    r_rsp_rdata;
  logic [1:0]       r_rsp_resp;

  logic             w_gnt_valid;
  logic [IW-1:0]    w_gnt_idx;
  logic [N_REQ-1:0] w_gnt_onehot;
  logic             w_aw_done, w_w_done;
  logic [AW-1:0]    w_addr_arr  [N_REQ];
  logic [DW-1:0]    w_wdata_arr [N_REQ];
  logic [SW-1:0]    w_wstrb_arr [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign w_addr_arr[gi]  = req_addr[gi*AW +: AW];
    assign w_wdata_arr[gi] = req_wdata[gi*DW +: DW];
    assign w_wstrb_arr[gi] = req_wstrb[gi*SW +: SW];
  end

  rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_rr_arbiter (
    .i_req    (req_valid),
    .i_ptr    (r_ptr),
    .o_valid  (w_gnt_valid),
    .o_idx    (w_gnt_idx),
    .o_onehot (w_gnt_onehot)
  );

  // Grant is combinational so a requester that drops req_valid before IDLE never sees a pulse.
  assign req_ready = (r_state == ST_IDLE && !areset) ? w_gnt_onehot : '0;

  // A channel counts as done once its valid has already dropped or is handshaking now.
  assign w_aw_done = ~r_awvalid | awready;
  assign w_w_done  = ~r_wvalid | wready;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      r_gnt_onehot <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_rsp_valid  <= '0;
      r_rsp_rdata  <= '0;
      r_rsp_resp   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_valid) begin
            r_gnt_onehot <= w_gnt_onehot;
            r_addr       <= w_addr_arr[w_gnt_idx];
            r_wdata      <= w_wdata_arr[w_gnt_idx];
            r_wstrb      <= w_wstrb_arr[w_gnt_idx];
            r_ptr        <= (w_gnt_idx == IW'(N_REQ - 1)) ? '0 : w_gnt_idx + IW'(1);
            if (req_write[w_gnt_idx]) begin
              r_state   <= ST_WR;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
            end else begin
              r_state   <= ST_RD_ADDR;
              r_arvalid <= 1'b1;
            end
          end
        end
        ST_WR: begin
          if (awready) r_awvalid <= 1'b0;
          if (wready)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (bvalid) begin
            r_bready    <= 1'b0;
            r_rsp_resp  <= bresp;
            r_rsp_rdata <= '0;
            r_rsp_valid <= r_gnt_onehot;
            r_state     <= ST_DONE;
          end
        end
        ST_RD_ADDR: begin
          if (arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (rvalid) begin
            r_rready    <= 1'b0;
            r_rsp_rdata <= rdata;
            r_rsp_resp  <= rresp;
            r_rsp_valid <= r_gnt_onehot;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_rsp_valid <= '0;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign awaddr    = r_addr;
  assign awprot    = PROT;
  assign awvalid   = r_awvalid;
  assign wdata     = r_wdata;
  assign wstrb     = r_wstrb;
  assign wvalid    = r_wvalid;
  assign bready    = r_bready;
  assign araddr    = r_addr;
  assign arprot    = PROT;
  assign arvalid   = r_arvalid;
  assign rready    = r_rready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_resp  = r_rsp_resp;

endmodule

// File: tb/tb_axi4_lite_master_arbiter.sv
// Directed bench: vector table of single transactions plus timeline sequences for waits, ordering and reset.
module tb_axi4_lite_master_arbiter;

  localparam int N = 2;

  logic          aclk = 1'b0;
  logic          areset;
  logic [N-1:0]  req_valid, req_write;
  logic [N*32-1:0] req_addr, req_wdata;
  logic [N*4-1:0]  req_wstrb;
  logic [N-1:0]  req_ready, rsp_valid;
  logic [31:0]   rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [31:0]   awaddr, wdata, araddr;
  logic [2:0]    awprot, arprot;
  logic [3:0]    wstrb;
  logic          awvalid, wvalid, bready, arvalid, rready;
  logic          awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0]    bresp = 2'b00, rresp = 2'b00;
  logic [31:0]   rdata = '0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // slave behaviour knobs
  int aw_wait = 0, w_wait = 0, ar_wait = 0, r_wait = 0;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0;
  logic [1:0]  s_bresp = 2'b00, s_rresp = 2'b00;
  logic [31:0] s_rdata = '0;

  axi4_lite_master_arbiter #(.N_REQ(N), .AW(32), .DW(32), .PROT(3'b000)) dut (
    .aclk(aclk), .areset(areset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc++;

  // Slave model: readies/responses change on the falling edge, after a programmable wait.
  always @(negedge aclk) begin
    if (awvalid) begin
      if (aw_cnt >= aw_wait) awready = 1'b1;
      else begin awready = 1'b0; aw_cnt++; end
    end else begin awready = 1'b0; aw_cnt = 0; end
    if (wvalid) begin
      if (w_cnt >= w_wait) wready = 1'b1;
      else begin wready = 1'b0; w_cnt++; end
    end else begin wready = 1'b0; w_cnt = 0; end
    if (arvalid) begin
      if (ar_cnt >= ar_wait) arready = 1'b1;
      else begin arready = 1'b0; ar_cnt++; end
    end else begin arready = 1'b0; ar_cnt = 0; end
    bvalid = bready;
    bresp  = s_bresp;
    if (rready) begin
      if (r_cnt >= r_wait) begin rvalid = 1'b1; rdata = s_rdata; rresp = s_rresp; end
      else begin rvalid = 1'b0; r_cnt++; end
    end else begin rvalid = 1'b0; r_cnt = 0; end
  end

  typedef struct {
    logic        wr;
    int          id;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [3:0]  strb;
    logic [1:0]  s_resp;
    logic [31:0] s_rdat;
    logic [1:0]  e_resp;
    logic [31:0] e_rdat;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_req(input int id, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    req_write[id]          = wr;
    req_addr[id*32 +: 32]  = a;
    req_wdata[id*32 +: 32] = d;
    req_wstrb[id*4 +: 4]   = s;
  endtask

  // Returns the req_ready vector of the grant cycle (zero if none within the budget).
  task automatic wait_grant(output logic [N-1:0] g);
    g = '0;
    for (int c = 0; c < 30; c++) begin
      #1;
      g = req_ready;
      if (g != '0) break;
      step();
    end
  endtask

  // Per-cycle check of the AXI handshake timeline for one transaction with given slave waits.
  task automatic run_timeline(input int id, input logic wr, input logic [31:0] a, input int aw_w,
                              input int w_w, input int ar_w, input logic [31:0] rd, input string nm);
    logic [N-1:0] g;
    logic [4:0]   exp_v;
    logic [N-1:0] one;
    int mx, last;
    aw_wait = aw_w; w_wait = w_w; ar_wait = ar_w; r_wait = 0;
    s_rdata = rd; s_rresp = 2'b00; s_bresp = 2'b00;
    one = '0; one[id] = 1'b1;
    set_req(id, wr, a, 32'hA0A0_0000 + a, 4'hF);
    req_valid[id] = 1'b1;
    wait_grant(g);
    check({nm, "_grant"}, g, one);
    step();
    req_valid[id] = 1'b0;
    mx   = (aw_w > w_w) ? aw_w : w_w;
    last = wr ? 3 + mx : 3 + ar_w;
    for (int c = 1; c <= last; c++) begin
      exp_v = {wr && c <= 1 + aw_w, wr && c <= 1 + w_w, wr && c == 2 + mx,
               !wr && c <= 1 + ar_w, !wr && c == 2 + ar_w};
      check($sformatf("%s_c%0d_valids", nm, c), {awvalid, wvalid, bready, arvalid, rready}, exp_v);
      check($sformatf("%s_c%0d_rsp_valid", nm, c), rsp_valid, (c == last) ? one : '0);
      if (exp_v[4]) check($sformatf("%s_c%0d_awaddr", nm, c), awaddr, a);
      if (exp_v[1]) check($sformatf("%s_c%0d_araddr", nm, c), araddr, a);
      if (c != last) step();
    end
    check({nm, "_rdata"}, rsp_rdata, wr ? 32'h0 : rd);
    check({nm, "_resp"}, rsp_resp, 2'b00);
    $display("txn %s id=%0d wr=%0d addr=%h done", nm, id, wr, a);
    step();
    aw_wait = 0; w_wait = 0; ar_wait = 0;
  endtask

  initial begin
    logic [N-1:0] g;
    logic [N-1:0] one;
    int lat, last_cyc;

    vecs[0] = '{1'b1, 0, 32'h10,  32'hDEAD_BEEF, 4'hF, 2'b00, 32'h1111_1111, 2'b00, 32'h0};
    vecs[1] = '{1'b0, 1, 32'h20,  32'h0,         4'h0, 2'b00, 32'hA5A5_5A5A, 2'b00, 32'hA5A5_5A5A};
    vecs[2] = '{1'b1, 0, 32'h30,  32'h0102_0304, 4'hF, 2'b10, 32'h2222_2222, 2'b10, 32'h0};
    vecs[3] = '{1'b0, 1, 32'h34,  32'h0,         4'h0, 2'b11, 32'hCAFE_F00D, 2'b11, 32'hCAFE_F00D};
    vecs[4] = '{1'b1, 1, 32'h44,  32'h5566_7788, 4'h3, 2'b00, 32'h3333_3333, 2'b00, 32'h0};
    vecs[5] = '{1'b0, 0, 32'h100, 32'h0,         4'h0, 2'b00, 32'h0BAD_F00D, 2'b00, 32'h0BAD_F00D};

    areset = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    step();
    step();
    req_valid = 2'b11;
    #1;
    check("reset_req_ready", req_ready, 2'b00);
    check("reset_outputs", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, awaddr, rsp_rdata, rsp_resp},
          '0);
    req_valid = '0;
    areset = 1'b0;
    step();

    for (int v = 0; v < 6; v++) begin
      s_bresp = vecs[v].s_resp; s_rresp = vecs[v].s_resp; s_rdata = vecs[v].s_rdat;
      one = '0; one[vecs[v].id] = 1'b1;
      set_req(vecs[v].id, vecs[v].wr, vecs[v].addr, vecs[v].wdat, vecs[v].strb);
      req_valid[vecs[v].id] = 1'b1;
      wait_grant(g);
      check($sformatf("v%0d_grant", v), g, one);
      step();
      req_valid[vecs[v].id] = 1'b0;
      if (vecs[v].wr)
        check($sformatf("v%0d_aw_w", v), {awvalid, wvalid, arvalid, awaddr, wdata, wstrb, awprot},
              {1'b1, 1'b1, 1'b0, vecs[v].addr, vecs[v].wdat, vecs[v].strb, 3'b000});
      else
        check($sformatf("v%0d_ar", v), {awvalid, wvalid, arvalid, araddr, arprot},
              {1'b0, 1'b0, 1'b1, vecs[v].addr, 3'b000});
      lat = 1;
      while (rsp_valid == '0 && lat < 40) begin
        step();
        lat++;
      end
      check($sformatf("v%0d_latency", v), lat, 3);
      check($sformatf("v%0d_rsp_valid", v), rsp_valid, one);
      check($sformatf("v%0d_rsp_rdata", v), rsp_rdata, vecs[v].e_rdat);
      check($sformatf("v%0d_rsp_resp", v), rsp_resp, vecs[v].e_resp);
      $display("txn v%0d id=%0d wr=%0d addr=%h resp=%0d lat=%0d", v, vecs[v].id, vecs[v].wr,
               vecs[v].addr, rsp_resp, lat);
      step();
    end
    s_bresp = 2'b00; s_rresp = 2'b00;

    run_timeline(1, 1'b0, 32'h20, 0, 0, 3, 32'h1234_5678, "rd_wait3");
    run_timeline(0, 1'b1, 32'h50, 2, 0, 0, 32'h0, "wr_w_first");
    run_timeline(1, 1'b1, 32'h54, 0, 2, 0, 32'h0, "wr_aw_first");

    // Read from req0 (pointer moves to 1), then reset while the data phase is waiting.
    r_wait = 10;
    s_rdata = 32'hFFFF_0000;
    set_req(0, 1'b0, 32'h40, 32'h0, 4'h0);
    req_valid[0] = 1'b1;
    wait_grant(g);
    check("rst_pre_grant", g, 2'b01);
    step();
    req_valid[0] = 1'b0;
    step();
    check("rst_in_rd_data", {arvalid, rready}, 2'b01);
    areset = 1'b1;
    set_req(0, 1'b0, 32'h200, 32'h0, 4'h0);
    set_req(1, 1'b0, 32'h300, 32'h0, 4'h0);
    req_valid = 2'b11;
    step();
    check("rst_axi_cleared", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, req_ready}, '0);
    areset = 1'b0;
    r_wait = 0;
    s_rdata = 32'h7777_0000;
    $display("txn reset_mid_read done");

    // Both requesters hold req_valid: grants must alternate starting at req0, spaced by one transaction.
    last_cyc = 0;
    for (int k = 0; k < 4; k++) begin
      wait_grant(g);
      one = '0; one[k % 2] = 1'b1;
      check($sformatf("rr_grant%0d", k), g, one);
      if (k > 0) check($sformatf("rr_gap%0d", k), cyc - last_cyc, 4);
      if (k == 0) check("rr_no_stale_rsp", rsp_valid, 2'b00);
      last_cyc = cyc;
      $display("txn rr%0d grant=%b cyc=%0d", k, g, cyc);
      step();
    end
    req_valid = '0;
    lat = 1;
    while (rsp_valid == '0 && lat < 40) begin
      step();
      lat++;
    end
    check("rr_last_rsp_valid", rsp_valid, 2'b10);
    check("rr_last_rdata", rsp_rdata, 32'h7777_0000);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
